// File: rtl/dca_matrix_wdata_serializer.sv
// dca_matrix_wdata_serializer: buffers tagged memory rows and serialises them into registered AXI W beats.
// Optional DCA_MATRIX_WDATA_STALL_CNT_EN adds a saturating wvalid&!wready stall counter port.
module dca_matrix_wdata_serializer #(
  parameter int BW_AXI_DATA = 32,
  parameter int NUM_ROW_BEAT = 8,
  parameter int ROW_DEPTH = 2,
  parameter int BW_LEN = 8,
  localparam int BW_ROW = BW_AXI_DATA * NUM_ROW_BEAT,
  localparam int BW_IDX = $clog2(NUM_ROW_BEAT),
  localparam int BW_STRB = BW_AXI_DATA / 8,
  localparam int BW_INFO = BW_LEN + BW_IDX + 1
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               clear,
  input  logic               enable,
  input  logic               row_valid,
  output logic               row_ready,
  input  logic [BW_ROW-1:0]  row_data,
  input  logic [BW_ROW/8-1:0] row_strb,
  input  logic [BW_INFO-1:0] row_info,
  input  logic               wready,
  output logic               wvalid,
  output logic [BW_AXI_DATA-1:0] wdata,
  output logic [BW_STRB-1:0] wstrb,
  output logic               wlast,
  output logic               row_done,
  output logic               txn_done,
  output logic               busy
`ifdef DCA_MATRIX_WDATA_STALL_CNT_EN
  ,output logic [31:0]       stall_cnt
`endif
);
  localparam int PW = ROW_DEPTH > 1 ? $clog2(ROW_DEPTH) : 1;
  localparam int CW = $clog2(ROW_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(ROW_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(ROW_DEPTH);
  localparam logic [BW_IDX-1:0] IDX_MAX = BW_IDX'(NUM_ROW_BEAT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  state_t state, state_nxt;

  logic [BW_ROW-1:0]   mem_data [ROW_DEPTH];
  logic [BW_ROW/8-1:0] mem_strb [ROW_DEPTH];
  logic [BW_INFO-1:0]  mem_info [ROW_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count, count_nxt;
  logic [BW_ROW-1:0]   head_data;
  logic [BW_ROW/8-1:0] head_strb;
  logic [BW_LEN-1:0]   head_len;
  logic [BW_IDX-1:0]   head_start, idx, cur_idx;
  logic                head_last, head_valid, free, load, push, pop, final_beat, wlast_row;
  logic [BW_LEN:0]     end_idx;

  assign head_data  = mem_data[rd_ptr];
  assign head_strb  = mem_strb[rd_ptr];
  assign head_len   = mem_info[rd_ptr][BW_LEN-1:0];
  assign head_start = mem_info[rd_ptr][BW_LEN +: BW_IDX];
  assign head_last  = mem_info[rd_ptr][BW_INFO-1];
  assign head_valid = count != '0;
  assign row_ready  = count != FULL_CNT;
  assign busy       = head_valid | wvalid;
  assign free       = !wvalid | wready;
  assign push       = row_valid & row_ready & !clear;
  assign load       = free & enable & head_valid & !clear;
  assign cur_idx    = (state == STREAM) ? idx : head_start;
  assign end_idx    = {1'b0, head_len} + (BW_LEN + 1)'(head_start);
  assign final_beat = ((BW_LEN + 1)'(cur_idx) == end_idx) | (cur_idx == IDX_MAX);
  assign pop        = load & final_beat;
  assign count_nxt  = count + CW'(push) - CW'(pop);

  // Row storage, written on push; entries need no reset.
  always_ff @(posedge clk)
    if (push) begin
      mem_data[wr_ptr] <= row_data;
      mem_strb[wr_ptr] <= row_strb;
      mem_info[wr_ptr] <= row_info;
    end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk)
    if (!rstnn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      count <= count_nxt;
    end

  // FSM state register.
  always_ff @(posedge clk)
    if (!rstnn) state <= IDLE;
    else state <= state_nxt;

  // Next state: LOAD selects the head's start_beat, STREAM continues from idx.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = push ? LOAD : IDLE;
      LOAD:    state_nxt = (pop && count_nxt != '0) ? LOAD : load ? STREAM : LOAD;
      STREAM:  state_nxt = pop ? (count_nxt != '0 ? LOAD : STREAM) :
                           (!head_valid && push) ? LOAD :
                           (!head_valid && free) ? IDLE : STREAM;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Registered W output stage, beat index and completion pulses.
  always_ff @(posedge clk)
    if (!rstnn || clear) begin
      wvalid <= 1'b0;
      wlast <= 1'b0;
      wdata <= '0;
      wstrb <= '0;
      wlast_row <= 1'b0;
      idx <= '0;
      row_done <= 1'b0;
      txn_done <= 1'b0;
    end else begin
      row_done <= wvalid & wready & wlast;
      txn_done <= wvalid & wready & wlast & wlast_row;
      if (load) begin
        wvalid <= 1'b1;
        wdata <= head_data[cur_idx*BW_AXI_DATA +: BW_AXI_DATA];
        wstrb <= head_strb[cur_idx*BW_STRB +: BW_STRB];
        wlast <= final_beat;
        wlast_row <= head_last;
        idx <= cur_idx + 1'b1;
      end else if (free) begin
        wvalid <= 1'b0;
        wlast <= 1'b0;
      end
    end

`ifdef DCA_MATRIX_WDATA_STALL_CNT_EN
  // Saturating count of cycles the sink holds off a valid beat.
  always_ff @(posedge clk)
    if (!rstnn || clear) stall_cnt <= '0;
    else if (wvalid && !wready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_dca_matrix_wdata_serializer.sv
// tb_dca_matrix_wdata_serializer: directed self-checking bench for the W data serializer.
module tb_dca_matrix_wdata_serializer;
  logic clk = 1'b0;
  logic rstnn, clear, enable, row_valid, row_ready, wready;
  logic [255:0] row_data;
  logic [31:0] row_strb;
  logic [11:0] row_info;
  logic wvalid, wlast, row_done, txn_done, busy;
  logic [31:0] wdata;
  logic [3:0] wstrb;
`ifdef DCA_MATRIX_WDATA_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dca_matrix_wdata_serializer dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_strb(row_strb), .row_info(row_info), .wready(wready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .row_done(row_done), .txn_done(txn_done), .busy(busy)
`ifdef DCA_MATRIX_WDATA_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [3:0] exp_strb(input int k);
    return 4'(k) ^ 4'hF;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input logic [31:0] base, input logic [11:0] info);
    for (int k = 0; k < 8; k++) begin
      row_data[k*32 +: 32] = base + 32'(k);
      row_strb[k*4 +: 4] = exp_strb(k);
    end
    row_info = info;
    row_valid = 1'b1;
  endtask

  task automatic test_reset;
    rstnn = 1'b0; clear = 1'b0; enable = 1'b1; wready = 1'b1; row_valid = 1'b0;
    row_data = '0; row_strb = '0; row_info = '0;
    repeat (3) step;
    total++; if (wvalid !== 1'b0) begin bad++; $display("FAIL reset_wvalid: got %b want 0", wvalid); end
    total++; if (wlast !== 1'b0) begin bad++; $display("FAIL reset_wlast: got %b want 0", wlast); end
    total++; if (wdata !== 32'h0 || wstrb !== 4'h0) begin bad++; $display("FAIL reset_data: got %h/%h want 0/0", wdata, wstrb); end
    total++; if (row_done !== 1'b0 || txn_done !== 1'b0) begin bad++; $display("FAIL reset_pulses: got %b%b want 00", row_done, txn_done); end
    total++; if (row_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_ready_busy: got %b%b want 10", row_ready, busy); end
    rstnn = 1'b1;
    step;
  endtask

  task automatic test_single;
    set_row(32'h1000, {1'b1, 3'd0, 8'd7});
    step;
    row_valid = 1'b0;
    total++; if (wvalid !== 1'b0) begin bad++; $display("FAIL single_latency: got wvalid=%b want 0 at T+1", wvalid); end
    step;
    for (int k = 0; k < 8; k++) begin
      total++; if (wvalid !== 1'b1 || wdata !== 32'h1000 + 32'(k) || wstrb !== exp_strb(k) || wlast !== (k == 7))
        begin bad++; $display("FAIL single_beat%0d: got v=%b d=%h s=%h l=%b want v=1 d=%h s=%h l=%b", k, wvalid, wdata, wstrb, wlast, 32'h1000 + 32'(k), exp_strb(k), k == 7); end
      step;
    end
    total++; if (row_done !== 1'b1 || txn_done !== 1'b1) begin bad++; $display("FAIL single_done: got %b%b want 11", row_done, txn_done); end
    total++; if (wvalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle: got v=%b busy=%b want 0 0", wvalid, busy); end
    step;
    total++; if (row_done !== 1'b0 || txn_done !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b%b want 00", row_done, txn_done); end
  endtask

  task automatic test_offset;
    set_row(32'h2000, {1'b0, 3'd3, 8'd2});
    step;
    row_valid = 1'b0;
    step;
    for (int k = 0; k < 3; k++) begin
      total++; if (wvalid !== 1'b1 || wdata !== 32'h2003 + 32'(k) || wstrb !== exp_strb(3 + k) || wlast !== (k == 2))
        begin bad++; $display("FAIL offset_beat%0d: got v=%b d=%h s=%h l=%b want v=1 d=%h s=%h l=%b", k, wvalid, wdata, wstrb, wlast, 32'h2003 + 32'(k), exp_strb(3 + k), k == 2); end
      step;
    end
    total++; if (row_done !== 1'b1 || txn_done !== 1'b0 || wvalid !== 1'b0) begin bad++; $display("FAIL offset_done: got rd=%b td=%b v=%b want 1 0 0", row_done, txn_done, wvalid); end
    step;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d;
    set_row(32'h3000, {1'b0, 3'd0, 8'd7});
    step;
    set_row(32'h4000, {1'b1, 3'd0, 8'd7});
    step;
    row_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      exp_d = (j < 8 ? 32'h3000 : 32'h4000) + 32'(j % 8);
      total++; if (wvalid !== 1'b1 || wdata !== exp_d || wlast !== (j == 7 || j == 15))
        begin bad++; $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", j, wvalid, wdata, wlast, exp_d, j == 7 || j == 15); end
      if (j == 8) begin
        total++; if (row_done !== 1'b1 || txn_done !== 1'b0) begin bad++; $display("FAIL b2b_first_done: got %b%b want 10", row_done, txn_done); end
      end
      step;
    end
    total++; if (row_done !== 1'b1 || txn_done !== 1'b1 || wvalid !== 1'b0) begin bad++; $display("FAIL b2b_done: got rd=%b td=%b v=%b want 1 1 0", row_done, txn_done, wvalid); end
    step;
  endtask

  task automatic test_backpressure;
    int rdy [6] = '{1, 0, 0, 1, 1, 1};
    int beat [6] = '{0, 1, 1, 1, 2, 3};
    set_row(32'h5000, {1'b1, 3'd0, 8'd3});
    step;
    row_valid = 1'b0;
    step;
    for (int i = 0; i < 6; i++) begin
      wready = rdy[i][0];
      total++; if (wvalid !== 1'b1 || wdata !== 32'h5000 + 32'(beat[i]) || wstrb !== exp_strb(beat[i]) || wlast !== (beat[i] == 3) || row_done !== 1'b0)
        begin bad++; $display("FAIL bp_cycle%0d: got v=%b d=%h s=%h l=%b rd=%b want v=1 d=%h s=%h l=%b rd=0", i, wvalid, wdata, wstrb, wlast, row_done, 32'h5000 + 32'(beat[i]), exp_strb(beat[i]), beat[i] == 3); end
      step;
    end
    wready = 1'b1;
    total++; if (row_done !== 1'b1 || txn_done !== 1'b1) begin bad++; $display("FAIL bp_done: got %b%b want 11", row_done, txn_done); end
`ifdef DCA_MATRIX_WDATA_STALL_CNT_EN
    total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL bp_stall_cnt: got %0d want 2", stall_cnt); end
`endif
    step;
  endtask

  task automatic test_full;
    logic [31:0] exp_d [5] = '{32'h6001, 32'h7000, 32'h7001, 32'h8000, 32'h8001};
    wready = 1'b0;
    set_row(32'h6000, {1'b0, 3'd0, 8'd1});
    step;
    set_row(32'h7000, {1'b0, 3'd0, 8'd1});
    total++; if (row_ready !== 1'b1) begin bad++; $display("FAIL full_ready_one: got %b want 1", row_ready); end
    step;
    set_row(32'h8000, {1'b1, 3'd0, 8'd1});
    for (int i = 0; i < 3; i++) begin
      total++; if (row_ready !== 1'b0 || wvalid !== 1'b1 || wdata !== 32'h6000)
        begin bad++; $display("FAIL full_hold%0d: got rr=%b v=%b d=%h want 0 1 00006000", i, row_ready, wvalid, wdata); end
      if (i == 2) wready = 1'b1;
      step;
    end
    total++; if (row_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop: got %b want 1", row_ready); end
    for (int i = 0; i < 5; i++) begin
      total++; if (wvalid !== 1'b1 || wdata !== exp_d[i] || wlast !== (i % 2 == 0))
        begin bad++; $display("FAIL full_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, wvalid, wdata, wlast, exp_d[i], i % 2 == 0); end
      if (i == 1) begin
        total++; if (row_done !== 1'b1 || txn_done !== 1'b0) begin bad++; $display("FAIL full_r1_done: got %b%b want 10", row_done, txn_done); end
      end
      step;
      row_valid = 1'b0;
    end
    total++; if (row_done !== 1'b1 || txn_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL full_done: got rd=%b td=%b busy=%b want 1 1 0", row_done, txn_done, busy); end
    step;
  endtask

  task automatic test_clear;
    set_row(32'h9000, {1'b1, 3'd0, 8'd7});
    step;
    row_valid = 1'b0;
    repeat (5) step;
    total++; if (wvalid !== 1'b1 || wdata !== 32'h9004) begin bad++; $display("FAIL clear_pre: got v=%b d=%h want 1 00009004", wvalid, wdata); end
    clear = 1'b1;
    step;
    clear = 1'b0;
    total++; if (wvalid !== 1'b0 || busy !== 1'b0 || row_ready !== 1'b1 || wlast !== 1'b0 || row_done !== 1'b0)
      begin bad++; $display("FAIL clear_state: got v=%b busy=%b rr=%b l=%b rd=%b want 0 0 1 0 0", wvalid, busy, row_ready, wlast, row_done); end
    set_row(32'hA000, {1'b1, 3'd0, 8'd1});
    step;
    row_valid = 1'b0;
    step;
    for (int k = 0; k < 2; k++) begin
      total++; if (wvalid !== 1'b1 || wdata !== 32'hA000 + 32'(k) || wlast !== (k == 1))
        begin bad++; $display("FAIL clear_fresh%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, wvalid, wdata, wlast, 32'hA000 + 32'(k), k == 1); end
      step;
    end
    total++; if (row_done !== 1'b1 || txn_done !== 1'b1) begin bad++; $display("FAIL clear_done: got %b%b want 11", row_done, txn_done); end
    step;
  endtask

  initial begin
    test_reset;
    test_single;
    test_offset;
    test_back_to_back;
    test_backpressure;
    test_full;
    test_clear;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
